// File: rtl/dmux_nway_fifo.sv
// 1-to-N flow-controlled demultiplexer with a DEPTH-entry FIFO per output channel.
// Optional broadcast input and logic are built when DMUX_BROADCAST_EN is defined.
module dmux_nway_fifo #(
    parameter int WIDTH = 4,
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N),
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   entrada,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] saida,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [7:0]         err_cnt
`ifdef DMUX_BROADCAST_EN
    ,
    input  logic               bcast
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wp  [N];
    logic [PW-1:0]    rp  [N];
    logic [CW-1:0]    cnt [N];
    logic [WIDTH-1:0] mem [N][DEPTH];

    logic         bc;
    logic         in_range;
    logic         sel_full;
    logic         any_full;
    logic [N-1:0] push;
    logic [N-1:0] pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // in_ready looks only at registered counts, never at out_ready.
    always_comb begin
`ifdef DMUX_BROADCAST_EN
        bc = bcast;
`else
        bc = 1'b0;
`endif
        in_range = ({1'b0, sel} < (SEL_W + 1)'(N));
        sel_full = 1'b0;
        any_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cnt[i] == CW'(DEPTH)) begin
                any_full = 1'b1;
                if (sel == SEL_W'(i))
                    sel_full = 1'b1;
            end
        end
        if (!rst_n)
            in_ready = 1'b0;
        else if (bc)
            in_ready = !any_full;
        else if (!in_range)
            in_ready = 1'b1;
        else
            in_ready = !sel_full;
        for (int i = 0; i < N; i++)
            push[i] = in_valid && in_ready && (bc || (in_range && sel == SEL_W'(i)));
    end

    always_comb begin
        saida = '0;
        for (int i = 0; i < N; i++) begin
            out_valid[i] = (cnt[i] != '0);
            if (out_valid[i])
                saida[i*WIDTH +: WIDTH] = mem[i][rp[i]];
        end
        pop = out_valid & out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
            err_cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i])
                    wp[i] <= nxt(wp[i]);
                if (pop[i])
                    rp[i] <= nxt(rp[i]);
                if (push[i] && !pop[i])
                    cnt[i] <= cnt[i] + CW'(1);
                else if (!push[i] && pop[i])
                    cnt[i] <= cnt[i] - CW'(1);
            end
            // Out-of-range words are accepted and discarded; only the drop is counted.
            if (in_valid && in_ready && !bc && !in_range && err_cnt != 8'hff)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (push[i])
                mem[i][wp[i]] <= entrada;
    end

endmodule

// File: tb/tb_dmux_nway_fifo.sv
// Directed bench for dmux_nway_fifo: an 8-channel instance checked through per-channel
// expected queues, plus a 6-channel instance for out-of-range select handling.
module tb_dmux_nway_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  entrada = '0;
    logic [2:0]  sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] saida;
    logic [7:0]  out_valid;
    logic [7:0]  ordy = '0;
    logic [7:0]  err_cnt;
`ifdef DMUX_BROADCAST_EN
    logic        bcast = 1'b0;
`endif

    logic [2:0]  sel6 = '0;
    logic        in_valid6 = 1'b0;
    logic        in_ready6;
    logic [23:0] saida6;
    logic [5:0]  ov6;
    logic [7:0]  err6;

    int n_vec  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    logic [3:0] exp_q[8][$];

    always #5 clk = ~clk;

    dmux_nway_fifo #(.WIDTH(4), .N(8), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .entrada(entrada), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .saida(saida), .out_valid(out_valid), .out_ready(ordy),
        .err_cnt(err_cnt)
`ifdef DMUX_BROADCAST_EN
        , .bcast(bcast)
`endif
    );

    dmux_nway_fifo #(.WIDTH(4), .N(6), .DEPTH(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .entrada(entrada), .sel(sel6), .in_valid(in_valid6),
        .in_ready(in_ready6), .saida(saida6), .out_valid(ov6), .out_ready(6'h3f),
        .err_cnt(err6)
`ifdef DMUX_BROADCAST_EN
        , .bcast(1'b0)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: valid must track the expected queue; transfers pop and compare the head.
    always @(negedge clk) begin
        if (mon_en) begin
            #1;
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("valid%0d", i), out_valid[i], exp_q[i].size() != 0);
                if (!out_valid[i])
                    chk($sformatf("zero%0d", i), saida[i*4 +: 4], 4'h0);
                else if (ordy[i] && exp_q[i].size() != 0)
                    chk($sformatf("data%0d", i), saida[i*4 +: 4], exp_q[i].pop_front());
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic [2:0] s, input bit exp_rdy);
        @(negedge clk);
        entrada = d; sel = s; in_valid = 1'b1;
        #1 chk("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        if (exp_rdy) exp_q[s].push_back(d);
        #1 in_valid = 1'b0;
    endtask

    task automatic probe(input logic [2:0] s, input bit exp_rdy);
        @(negedge clk);
        sel = s; in_valid = 1'b0;
        #1 chk("probe_ready", in_ready, exp_rdy);
        @(posedge clk);
        #1;
    endtask

`ifdef DMUX_BROADCAST_EN
    task automatic bsend(input logic [3:0] d);
        @(negedge clk);
        entrada = d; bcast = 1'b1; in_valid = 1'b1;
        #1 chk("bcast_ready", in_ready, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 8; i++) exp_q[i].push_back(d);
        #1 in_valid = 1'b0; bcast = 1'b0;
    endtask
`endif

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mid_chk();
        @(negedge clk);
        #2;
    endtask

    initial begin
        // reset values
        #3;
        chk("rst_valid", out_valid, 8'h00);
        chk("rst_saida", saida, 32'h0);
        chk("rst_err", err_cnt, 8'h00);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_err6", err6, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        probe(7, 1'b1);
        probe(0, 1'b1);

        // routing and one-cycle latency
        send(4'hA, 3, 1'b1);
        mid_chk();
        chk("route_valid", out_valid, 8'h08);
        chk("route_saida", saida, 32'h0000_A000);
        @(posedge clk); #1 ordy = 8'h08;
        @(posedge clk); #1 ordy = 8'h00;
        mid_chk();
        chk("route_popped", out_valid, 8'h00);

        // full channel and backpressure
        send(4'h1, 5, 1'b1);
        send(4'h2, 5, 1'b1);
        send(4'h3, 5, 1'b0);
        probe(2, 1'b1);
        ordy = 8'h20;
        probe(5, 1'b0);
        probe(5, 1'b1);
        ordy = 8'h00;
        mid_chk();
        chk("full_drained", out_valid, 8'h00);

        // simultaneous push and pop, then pointer wrap
        send(4'h3, 0, 1'b1);
        ordy = 8'h01;
        send(4'h7, 0, 1'b1);
        ordy = 8'h00;
        mid_chk();
        chk("pp_valid", out_valid, 8'h01);
        chk("pp_head", saida, 32'h0000_0007);
        probe(0, 1'b1);
        ordy = 8'h01;
        for (int k = 0; k < 8; k++) send(4'(k + 8), 0, 1'b1);
        idle(2);
        ordy = 8'h00;

`ifdef DMUX_BROADCAST_EN
        send(4'hC, 2, 1'b1);
        send(4'hD, 2, 1'b1);
        bcast = 1'b1;
        probe(0, 1'b0);
        ordy = 8'h04;
        probe(0, 1'b0);
        ordy = 8'h00;
        bcast = 1'b0;
        bsend(4'h5);
        mid_chk();
        chk("bc_valid", out_valid, 8'hFF);
        chk("bc_saida", saida, 32'h5555_5D55);
        chk("bc_err", err_cnt, 8'h00);
        ordy = 8'hFF;
        idle(4);
        ordy = 8'h00;
`endif

        // reset in the middle of operation discards buffered words
        send(4'h9, 1, 1'b1);
        send(4'h6, 4, 1'b1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 8'h00);
        chk("mid_rst_saida", saida, 32'h0);
        chk("mid_rst_ready", in_ready, 1'b0);
        for (int i = 0; i < 8; i++) exp_q[i].delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 mon_en = 1'b1;
        probe(4, 1'b1);

        // out-of-range select on the 6-channel instance
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            sel6 = 3'd7; in_valid6 = 1'b1;
            #1;
            chk("oor_ready", in_ready6, 1'b1);
            chk("oor_valid", ov6, 6'h00);
            @(posedge clk); #1;
            chk("oor_err", err6, (k < 255) ? 8'(k) : 8'd255);
        end
        @(negedge clk);
        entrada = 4'hB; sel6 = 3'd2;
        #1 chk("inr_ready", in_ready6, 1'b1);
        @(posedge clk); #1 in_valid6 = 1'b0;
        mid_chk();
        chk("inr_valid", ov6, 6'b000100);
        chk("inr_err", err6, 8'd255);

        // drain
        ordy = 8'hFF;
        idle(4);
        begin
            int left = 0;
            for (int i = 0; i < 8; i++) left += exp_q[i].size();
            chk("drain_left", left, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
